// File: rtl/hdmi_pkg.sv
// Shared types and TMDS character constants for the HDMI period scheduler.
package hdmi_pkg;
  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } period_e;

  // Indexed by {c1,c0}.
  localparam logic [9:0] TMDS_CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] VIDEO_GB_CH0  = 10'b1011001100;
  localparam logic [9:0] VIDEO_GB_CH1  = 10'b0100110011;
  localparam logic [9:0] VIDEO_GB_CH2  = 10'b1011001100;
  localparam logic [9:0] CLK_WORD_DFLT = 10'b0000011111;
endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// Scheduler bus: timing/video from the encoder in, TMDS words to the serializer out.
// dvi_mode_i exists only when HDMI_SCHED_DVI_EN is defined.
interface hdmi_period_scheduler_if #(
  parameter int NUM_PHY_CHANNELS = 4,
  parameter int WORD_WIDTH       = 10
);
  import hdmi_pkg::*;

  logic                                        advance_i;
  logic                                        de_i;
  logic                                        hsync_i;
  logic                                        vsync_i;
  logic [2:0][WORD_WIDTH-1:0]                  video_word_i;
  logic                                        err_clr_i;
  logic [NUM_PHY_CHANNELS-1:0][WORD_WIDTH-1:0] word_o;
  period_e                                     period_o;
  logic                                        err_short_blank_o;
`ifdef HDMI_SCHED_DVI_EN
  logic                                        dvi_mode_i;
`endif

  modport master (
`ifdef HDMI_SCHED_DVI_EN
    output dvi_mode_i,
`endif
    output advance_i, de_i, hsync_i, vsync_i, video_word_i, err_clr_i,
    input  word_o, period_o, err_short_blank_o
  );

  modport slave (
`ifdef HDMI_SCHED_DVI_EN
    input  dvi_mode_i,
`endif
    input  advance_i, de_i, hsync_i, vsync_i, video_word_i, err_clr_i,
    output word_o, period_o, err_short_blank_o
  );
endinterface

// File: rtl/hdmi_stream_delay.sv
// Advance-gated delay line of DEPTH stages; tail_o is the sample taken DEPTH strobes ago.
module hdmi_stream_delay #(
  parameter int DEPTH = 10,
  parameter int W     = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         adv_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] tail_o
);
  logic [DEPTH-1:0][W-1:0] pipe;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) pipe <= '0;
    else if (adv_i) begin
      pipe[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end

  assign tail_o = pipe[DEPTH-1];
endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI TMDS period scheduler: control / preamble / guard / video sequencing per serializer slot.
// Optional HDMI_SCHED_DVI_EN adds dvi_mode_i, which bypasses preamble and guard band.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int         NUM_PHY_CHANNELS = 4,
  parameter int         WORD_WIDTH       = 10,
  parameter int         PREAMBLE_LEN     = 8,
  parameter int         GUARD_LEN        = 2,
  parameter logic [9:0] CLK_WORD         = CLK_WORD_DFLT
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  hdmi_period_scheduler_if.slave bus
);
  localparam int DELAY = PREAMBLE_LEN + GUARD_LEN;
  localparam int CW    = $clog2(DELAY + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(DELAY - 1);

  typedef logic [2:0][WORD_WIDTH-1:0] chars_t;
  typedef struct packed {
    logic   de;
    logic   hsync;
    logic   vsync;
    chars_t video;
  } slot_t;

  slot_t         s_in, s_tail;
  period_e       st, nxt;
  logic [CW-1:0] cnt;
  logic          de_last, rise, dvi, err_set, err_q;
  chars_t        data_q;

  assign s_in = {bus.de_i, bus.hsync_i, bus.vsync_i, bus.video_word_i};

  hdmi_stream_delay #(.DEPTH(DELAY), .W($bits(slot_t))) u_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .adv_i  (bus.advance_i),
    .d_i    (s_in),
    .tail_o (s_tail)
  );

`ifdef HDMI_SCHED_DVI_EN
  // Mode is latched while idle in CTRL so a change mid-line cannot split a period.
  logic dvi_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) dvi_q <= 1'b0;
    else if (bus.advance_i && st == CTRL) dvi_q <= bus.dvi_mode_i;
  assign dvi = (st == CTRL) ? bus.dvi_mode_i : dvi_q;
`else
  assign dvi = 1'b0;
`endif

  assign rise    = bus.de_i & ~de_last;
  assign err_set = ~dvi & ((st == CTRL) ? s_tail.de : rise);

  // Delayed video already in flight wins over a new rising edge while in CTRL.
  always_comb begin
    nxt = st;
    unique case (st)
      CTRL:     nxt = s_tail.de ? VIDEO : (rise && !dvi) ? PREAMBLE : CTRL;
      PREAMBLE: nxt = rise ? CTRL : (cnt == PRE_LAST) ? GUARD : PREAMBLE;
      GUARD:    nxt = rise ? CTRL : (cnt != GRD_LAST) ? GUARD : s_tail.de ? VIDEO : CTRL;
      VIDEO:    nxt = s_tail.de ? VIDEO : CTRL;
      default:  nxt = CTRL;
    endcase
  end

  function automatic chars_t chars(period_e p, slot_t s);
    chars_t c;
    c[0] = TMDS_CTRL_CODE[{s.vsync, s.hsync}];
    c[1] = TMDS_CTRL_CODE[0];
    c[2] = TMDS_CTRL_CODE[0];
    unique case (p)
      PREAMBLE: c[1] = TMDS_CTRL_CODE[1];
      GUARD:    c = {VIDEO_GB_CH2, VIDEO_GB_CH1, VIDEO_GB_CH0};
      VIDEO:    c = s.video;
      default:  ;
    endcase
    return c;
  endfunction

  // cnt counts strobes since the accepted rising edge across preamble and guard.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      st      <= CTRL;
      cnt     <= '0;
      de_last <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= {3{TMDS_CTRL_CODE[0]}};
    end else if (bus.advance_i) begin
      st      <= nxt;
      de_last <= bus.de_i;
      data_q  <= chars(nxt, s_tail);
      if (st == CTRL) cnt <= '0;
      else if (st != VIDEO) cnt <= cnt + CW'(1);
      if (err_set) err_q <= 1'b1;
      else if (bus.err_clr_i) err_q <= 1'b0;
    end

  assign bus.period_o          = st;
  assign bus.err_short_blank_o = err_q;

  for (genvar ch = 0; ch < NUM_PHY_CHANNELS; ch++) begin : g_ch
    if (ch < 3) begin : g_data
      assign bus.word_o[ch] = data_q[ch];
    end else begin : g_clk
      assign bus.word_o[ch] = CLK_WORD;
    end
  end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler: randomized lines against a slot-level reference model.
module tb_hdmi_period_scheduler;
  localparam int P = 8;
  localparam int G = 2;
  localparam int D = P + G;
  localparam logic [9:0] C0   = 10'b1101010100;
  localparam logic [9:0] C1   = 10'b0010101011;
  localparam logic [9:0] C2   = 10'b0101010100;
  localparam logic [9:0] C3   = 10'b1010101011;
  localparam logic [9:0] CLKW = 10'b0000011111;

  typedef struct packed {logic de; logic hs; logic vs; logic [2:0][9:0] v;} smp_t;
  typedef struct {logic [3:0][9:0] w; logic [1:0] p; logic e;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   dvi_cur = 1'b0;
  logic [9:0] code [4];
  exp_t expq[$];
  exp_t last_exp, rst_exp;

  // Reference model state: period (0..3), strobes since accepted rise, flags, input history.
  smp_t hist[$];
  int   mp, since;
  bit   merr, mdvi, mlast_de;

  always #5 clk = ~clk;

  hdmi_period_scheduler_if #(.NUM_PHY_CHANNELS(4), .WORD_WIDTH(10)) bus ();

  hdmi_period_scheduler #(
    .NUM_PHY_CHANNELS(4), .WORD_WIDTH(10), .PREAMBLE_LEN(P), .GUARD_LEN(G), .CLK_WORD(CLKW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input exp_t e, input string nm);
    n_chk++;
    if (bus.word_o === e.w && bus.period_o === e.p && bus.err_short_blank_o === e.e) n_pass++;
    else $display("FAIL %s: got word=%h period=%0d err=%0b, want word=%h period=%0d err=%0b",
                  nm, bus.word_o, bus.period_o, bus.err_short_blank_o, e.w, e.p, e.e);
  endtask

  function automatic void model_reset();
    smp_t z = '0;
    mp = 0; since = 0; merr = 0; mdvi = 0; mlast_de = 0;
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back(z);
    expq.delete();
  endfunction

  function automatic void model_step(input smp_t s, input bit clr, input bit dvi_in);
    smp_t d;
    bit   rise, dvi, set;
    exp_t e;
    d = hist.pop_front();
    hist.push_back(s);
    rise = s.de && !mlast_de;
    mlast_de = s.de;
    dvi = (mp == 0) ? dvi_in : mdvi;
    if (mp == 0) mdvi = dvi_in;
    set = !dvi && ((mp == 0) ? d.de : rise);
    if (clr) merr = 0;
    if (set) merr = 1;
    case (mp)
      0: if (d.de) mp = 3;
         else if (rise && !dvi) begin mp = 1; since = 0; end
      1, 2: if (rise) mp = 0;
            else begin
              since++;
              mp = (since < P) ? 1 : (since < P + G) ? 2 : (d.de ? 3 : 0);
            end
      default: if (!d.de) mp = 0;
    endcase
    e.w[3] = CLKW;
    e.w[0] = code[{d.vs, d.hs}];
    e.w[1] = C0;
    e.w[2] = C0;
    case (mp)
      1: e.w[1] = C1;
      2: begin e.w[0] = 10'b1011001100; e.w[1] = 10'b0100110011; e.w[2] = 10'b1011001100; end
      3: e.w[2:0] = d.v;
      default: ;
    endcase
    e.p = 2'(mp);
    e.e = merr;
    expq.push_back(e);
  endfunction

  function automatic smp_t rand_smp();
    smp_t r;
    r.de = 1'($urandom);
    r.hs = 1'($urandom);
    r.vs = 1'($urandom);
    for (int c = 0; c < 3; c++) r.v[c] = 10'($urandom);
    return r;
  endfunction

  task automatic slot(input bit adv, input smp_t s, input bit clr);
    bit dv = 1'b0;
    @(negedge clk); #1;
    bus.advance_i = adv; bus.de_i = s.de; bus.hsync_i = s.hs; bus.vsync_i = s.vs;
    bus.video_word_i = s.v; bus.err_clr_i = clr;
`ifdef HDMI_SCHED_DVI_EN
    bus.dvi_mode_i = dvi_cur;
    dv = dvi_cur;
`endif
    if (adv && rst_n) model_step(s, clr, dv);
  endtask

  // gap: 0 back-to-back strobes, 1 one idle slot before each, 2 random idle slots
  task automatic strobe(input smp_t s, input bit clr, input int gap);
    if (gap == 1) slot(1'b0, rand_smp(), 1'($urandom));
    else if (gap == 2) while ($urandom_range(3) == 0) slot(1'b0, rand_smp(), 1'($urandom));
    slot(1'b1, s, clr);
  endtask

  task automatic send_line(input int act, input int blank, input int gap);
    smp_t s;
    for (int i = 0; i < act; i++) begin
      s = rand_smp(); s.de = 1'b1; s.hs = 1'b0; s.vs = 1'b0;
      strobe(s, 1'b0, gap);
    end
    for (int i = 0; i < blank; i++) begin
      s = rand_smp(); s.de = 1'b0;
      strobe(s, $urandom_range(99) < 3, gap);
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk); #2;
    rst_n = 1'b0;
    bus.advance_i = 1'b0; bus.de_i = 1'b0; bus.err_clr_i = 1'b0;
    model_reset();
    #1 check(rst_exp, "async_reset");
    repeat (hold) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every falling edge after a strobe pops one expected slot; otherwise outputs must hold.
  initial begin
    bit   stb;
    exp_t e;
    forever begin
      @(posedge clk);
      stb = bus.advance_i && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        check(rst_exp, "reset_state");
        last_exp = rst_exp;
      end else if (stb) begin
        if (expq.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard_empty: strobe seen, expected queue size=0 want >=1");
        end else begin
          e = expq.pop_front();
          check(e, "strobe_word");
          last_exp = e;
        end
      end else check(last_exp, "hold");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d want completion", n_chk);
    $fatal(1);
  end

  initial begin
    smp_t s;
    code[0] = C0; code[1] = C1; code[2] = C2; code[3] = C3;
    rst_exp.w = {CLKW, C0, C0, C0}; rst_exp.p = 2'd0; rst_exp.e = 1'b0;
    last_exp = rst_exp;
    bus.advance_i = 1'b0; bus.de_i = 1'b0; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
    bus.video_word_i = '0; bus.err_clr_i = 1'b0;
`ifdef HDMI_SCHED_DVI_EN
    bus.dvi_mode_i = 1'b0;
`endif
    model_reset();
    do_reset(3);

    // Idle blanking with hsync high, then a full 640-pixel line.
    for (int i = 0; i < 50; i++) begin s = '0; s.hs = 1'b1; strobe(s, 1'b0, 0); end
    send_line(640, 20, 0);
    // Strobe alternating with idle slots across preamble and guard.
    send_line(30, 20, 1);
    // Short blanking, then clear the sticky flag.
    send_line(40, 4, 0);
    send_line(40, 20, 0);
    s = '0; strobe(s, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin s = '0; strobe(s, 1'b0, 0); end

    for (int l = 0; l < 30; l++)
      send_line($urandom_range(80, 12),
                ($urandom_range(3) == 0) ? $urandom_range(6, 2) : $urandom_range(40, 11), 2);

    // Reset in the middle of active video, then a fresh line.
    for (int i = 0; i < 15; i++) begin s = rand_smp(); s.de = 1'b1; strobe(s, 1'b0, 0); end
    do_reset(2);
    for (int i = 0; i < 5; i++) begin s = '0; strobe(s, 1'b0, 0); end
    send_line(30, 20, 0);

`ifdef HDMI_SCHED_DVI_EN
    dvi_cur = 1'b1;
    for (int l = 0; l < 5; l++) send_line($urandom_range(60, 12), $urandom_range(40, 11), 2);
    dvi_cur = 1'b0;
    send_line(0, 20, 0);
`endif

    repeat (3) slot(1'b0, rand_smp(), 1'b0);
    n_chk++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: pending=%0d want 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
